// File: rtl/deserializer_multilane.sv
// deserializer_multilane
// Collects LANES serial bits per enabled beat into DATA_WIDTH-bit words and
// queues completed words in a small output FIFO with ready/valid handshake.
//
// Optional feature: define DESER_PARITY_EN to require one extra beat per
// frame carrying even parity (serial_in_i[0]); failing words are dropped.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   serial_in_i    one bit per lane, sampled on beats (lane LANES-1 = MSB of beat)
//   enable_i       beat qualifier
//   start_i        frame start marker
//   parallel_out_o FIFO head word ('0 while empty)
//   valid_o        FIFO not empty
//   ready_i        consumer accepts head word when valid_o=1
//   level_o        FIFO occupancy
//   overflow_o     pulse: completed word dropped because FIFO full
//   frame_err_o    pulse: start_i arrived mid-frame
//   parity_err_o   pulse: parity mismatch (constant 0 without DESER_PARITY_EN)
module deserializer_multilane #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 1,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [LANES-1:0]                serial_in_i,
    input  logic                            enable_i,
    input  logic                            start_i,
    output logic [DATA_WIDTH-1:0]           parallel_out_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [$clog2(FIFO_DEPTH):0]     level_o,
    output logic                            overflow_o,
    output logic                            frame_err_o,
    output logic                            parity_err_o
);

    localparam int unsigned BEATS = DATA_WIDTH / LANES;
    localparam int unsigned CW    = $clog2(BEATS) + 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_base;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_base;
    logic                  active;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_word;
    logic                  frame_err_q, frame_err_d;
`ifdef DESER_PARITY_EN
    logic                  in_parity;
    logic                  parity_err_q, parity_err_d;
`endif

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  overflow_q, overflow_d;
    logic                  pop, full, push_ok;

    // Shift one beat in; a double-width concatenation keeps this legal when BEATS=1.
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr,
                                                       input logic [LANES-1:0]      d);
        logic [DATA_WIDTH+LANES-1:0] cat;
        if (MSB_FIRST != 0) begin
            cat = {sr, d};
            return cat[DATA_WIDTH-1:0];
        end else begin
            cat = {d, sr};
            return cat[DATA_WIDTH+LANES-1:LANES];
        end
    endfunction

    // Next-state and frame datapath; start_i always restarts from a clean frame.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        push        = 1'b0;
        push_word   = sr_q;
        frame_err_d = 1'b0;
        active      = (state_q != IDLE);
        sr_base     = sr_q;
        cnt_base    = cnt_q;
`ifdef DESER_PARITY_EN
        parity_err_d = 1'b0;
        in_parity    = (state_q == PARITY);
`endif
        if (start_i) begin
            frame_err_d = active;
            active      = 1'b1;
            sr_base     = '0;
            cnt_base    = '0;
            sr_d        = '0;
            cnt_d       = '0;
            state_d     = SHIFT;
`ifdef DESER_PARITY_EN
            in_parity   = 1'b0;
`endif
        end
        if (active && enable_i) begin
`ifdef DESER_PARITY_EN
            if (in_parity) begin
                state_d   = IDLE;
                cnt_d     = '0;
                push_word = sr_q;
                if (^{sr_q, serial_in_i[0]}) parity_err_d = 1'b1;
                else                         push         = 1'b1;
            end else begin
`else
            begin
`endif
                sr_d = shift_in(sr_base, serial_in_i);
                if (cnt_base == CW'(BEATS - 1)) begin
                    cnt_d = '0;
`ifdef DESER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d   = IDLE;
                    push      = 1'b1;
                    push_word = sr_d;
`endif
                end else begin
                    cnt_d   = cnt_base + CW'(1);
                    state_d = SHIFT;
                end
            end
        end
    end

    // FIFO control; a push into a full FIFO succeeds only alongside a pop.
    always_comb begin
        pop        = valid_q & ready_i;
        full       = (level_q == LW'(FIFO_DEPTH));
        push_ok    = push & (~full | pop);
        overflow_d = push & full & ~pop;
        level_d    = level_q + LW'(push_ok) - LW'(pop);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        if (level_d == '0)
            head_d = '0;
        else if (push_ok && (wr_ptr_q == rd_ptr_d))
            head_d = push_word;
        else
            head_d = mem[rd_ptr_d];
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            valid_q     <= 1'b0;
            head_q      <= '0;
            overflow_q  <= 1'b0;
`ifdef DESER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_q + AW'(push_ok);
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            valid_q     <= (level_d != '0);
            head_q      <= head_d;
            overflow_q  <= overflow_d;
`ifdef DESER_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care while not covered by level_q.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= push_word;
    end

    assign parallel_out_o = head_q;
    assign valid_o        = valid_q;
    assign level_o        = level_q;
    assign overflow_o     = overflow_q;
    assign frame_err_o    = frame_err_q;
`ifdef DESER_PARITY_EN
    assign parity_err_o   = parity_err_q;
`else
    assign parity_err_o   = 1'b0;
`endif

endmodule
